// File: rtl/br_deskew_credit_buffer.sv
// Credit-managed receive FIFO behind the deskew stage: accepts a non-backpressurable
// push stream, re-presents it as ready/valid, and returns one credit per completed pop.
module br_deskew_credit_buffer #(
    parameter int Width                   = 1,
    parameter int Depth                   = 2,
    parameter int EnableAssertFinalEmpty  = 1,
    parameter int EnableIntegrationAssert = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_valid_i,
    input  logic [Width-1:0]             push_data_i,
    output logic                         pop_valid_o,
    input  logic                         pop_ready_i,
    output logic [Width-1:0]             pop_data_o,
    output logic                         credit_return_o,
    output logic [$clog2(Depth+1)-1:0]   occupancy_o,
    output logic                         full_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int OccW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [OccW-1:0] DepthOcc = OccW'(Depth);

    // Depth need not be a power of two, so the wrap to zero is explicit.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        logic [PtrW-1:0] nxt;
        if (ptr == LastPtr) begin
            nxt = {PtrW{1'b0}};
        end else begin
            nxt = ptr + PtrW'(1);
        end
        return nxt;
    endfunction

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [OccW-1:0]  occ_q, occ_d;
    logic             full_q, full_d;
    logic             pop_valid_q, pop_valid_d;
    logic             credit_q, credit_d;
    logic             push_s, pop_s;
    logic             wptr_wrap_s, rptr_wrap_s;

    // A push arriving while full is dropped; pops need a valid head.
    assign push_s      = push_valid_i && !full_q;
    assign pop_s       = pop_valid_q && pop_ready_i;
    assign wptr_wrap_s = push_s && (wptr_q == LastPtr);
    assign rptr_wrap_s = pop_s && (rptr_q == LastPtr);

    // Next-state for pointers, occupancy and the flags derived from it.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        occ_d       = occ_q;
        full_d      = 1'b0;
        pop_valid_d = 1'b0;
        credit_d    = 1'b0;
        if (push_s) begin
            wptr_d = next_ptr(wptr_q);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = next_ptr(rptr_q);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase
        full_d      = (occ_d == DepthOcc);
        pop_valid_d = (occ_d != {OccW{1'b0}});
        credit_d    = pop_s;
    end

    // Control state register; reset discards any stored entries.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q      <= {PtrW{1'b0}};
            rptr_q      <= {PtrW{1'b0}};
            occ_q       <= {OccW{1'b0}};
            full_q      <= 1'b0;
            pop_valid_q <= 1'b0;
            credit_q    <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            occ_q       <= occ_d;
            full_q      <= full_d;
            pop_valid_q <= pop_valid_d;
            credit_q    <= credit_d;
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    assign pop_valid_o     = pop_valid_q;
    assign pop_data_o      = mem_q[rptr_q];
    assign credit_return_o = credit_q;
    assign occupancy_o     = occ_q;
    assign full_o          = full_q;

    br_deskew_credit_buffer_chk #(
        .Depth                   (Depth),
        .OccW                    (OccW),
        .EnableAssertFinalEmpty  (EnableAssertFinalEmpty),
        .EnableIntegrationAssert (EnableIntegrationAssert)
    ) u_chk (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .push_valid_i    (push_valid_i),
        .pop_valid_i     (pop_valid_q),
        .pop_ready_i     (pop_ready_i),
        .full_i          (full_q),
        .occupancy_i     (occ_q),
        .credit_return_i (credit_q),
        .wptr_wrap_i     (wptr_wrap_s),
        .rptr_wrap_i     (rptr_wrap_s)
    );

endmodule

// Protocol and implementation properties plus coverage for the credit buffer.
module br_deskew_credit_buffer_chk #(
    parameter int Depth                   = 2,
    parameter int OccW                    = 2,
    parameter int EnableAssertFinalEmpty  = 1,
    parameter int EnableIntegrationAssert = 1
) (
    input logic            clk_i,
    input logic            rst_i,
    input logic            push_valid_i,
    input logic            pop_valid_i,
    input logic            pop_ready_i,
    input logic            full_i,
    input logic [OccW-1:0] occupancy_i,
    input logic            credit_return_i,
    input logic            wptr_wrap_i,
    input logic            rptr_wrap_i
);

    generate
        if (EnableIntegrationAssert != 0) begin : g_integ
            // Upstream credit discipline must never overrun the buffer.
            a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
                !(push_valid_i && full_i))
                else $error("push_valid while full: beat dropped");
        end
    endgenerate

    a_occ_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        (occupancy_i <= OccW'(Depth)))
        else $error("occupancy above Depth");

    c_full:      cover property (@(posedge clk_i) disable iff (rst_i) full_i);
    c_push_pop:  cover property (@(posedge clk_i) disable iff (rst_i)
        push_valid_i && pop_valid_i && pop_ready_i);
    c_ptr_wrap:  cover property (@(posedge clk_i) disable iff (rst_i)
        wptr_wrap_i || rptr_wrap_i);

    // End-of-test drain check.
    final begin
        if (EnableAssertFinalEmpty != 0) begin
            a_final_empty: assert ((occupancy_i == {OccW{1'b0}}) && (credit_return_i == 1'b0))
                else $error("buffer not empty or credit pending at end of test");
        end
    end

endmodule

// File: tb/tb_br_deskew_credit_buffer.sv
// Directed bench for br_deskew_credit_buffer (Depth=3, Width=8) with a credit-limited random phase.
module tb_br_deskew_credit_buffer;

    localparam int W = 8;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         push_valid;
    logic [W-1:0] push_data;
    logic         pop_valid;
    logic         pop_ready;
    logic [W-1:0] pop_data;
    logic         credit_return;
    logic [1:0]   occupancy;
    logic         full;

    int n_pass  = 0;
    int n_total = 0;

    br_deskew_credit_buffer #(
        .Width                   (W),
        .Depth                   (D),
        .EnableAssertFinalEmpty  (1),
        .EnableIntegrationAssert (0)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .push_valid_i    (push_valid),
        .push_data_i     (push_data),
        .pop_valid_o     (pop_valid),
        .pop_ready_i     (pop_ready),
        .pop_data_o      (pop_data),
        .credit_return_o (credit_return),
        .occupancy_o     (occupancy),
        .full_o          (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_state(input string tag);
        chk({tag, ".pop_valid"}, 32'(pop_valid), 32'd0);
        chk({tag, ".credit"},    32'(credit_return), 32'd0);
        chk({tag, ".occ"},       32'(occupancy), 32'd0);
        chk({tag, ".full"},      32'(full), 32'd0);
    endtask

    logic [W-1:0] q[$];
    int credits;
    int n_pop;
    int n_cred;

    initial begin
        rst        = 1'b1;
        push_valid = 1'b0;
        push_data  = 8'h00;
        pop_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle_state("reset");
        rst = 1'b0;

        // Single beat: push at t0, visible at t1, credit at t2 only.
        push_valid = 1'b1; push_data = 8'h0A;
        tick();
        chk("t1.pop_valid", 32'(pop_valid), 32'd1);
        chk("t1.pop_data",  32'(pop_data), 32'h0A);
        chk("t1.occ",       32'(occupancy), 32'd1);
        chk("t1.credit",    32'(credit_return), 32'd0);
        push_valid = 1'b0; pop_ready = 1'b1;
        tick();
        chk("t2.credit",    32'(credit_return), 32'd1);
        chk("t2.occ",       32'(occupancy), 32'd0);
        chk("t2.pop_valid", 32'(pop_valid), 32'd0);
        pop_ready = 1'b0;
        tick();
        chk("t3.credit",    32'(credit_return), 32'd0);

        // Fill with 1,2,3 then drain in order.
        for (int i = 1; i <= 3; i++) begin
            push_valid = 1'b1; push_data = 8'(i);
            tick();
        end
        push_valid = 1'b0;
        chk("fill.full",     32'(full), 32'd1);
        chk("fill.occ",      32'(occupancy), 32'd3);
        chk("fill.pop_data", 32'(pop_data), 32'd1);
        tick();
        chk("hold.pop_data", 32'(pop_data), 32'd1);
        chk("hold.credit",   32'(credit_return), 32'd0);
        pop_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            chk("drain.data", 32'(pop_data), 32'(i));
            tick();
            chk("drain.credit", 32'(credit_return), 32'd1);
            chk("drain.occ",    32'(occupancy), 32'(3 - i));
            chk("drain.full",   32'(full), 32'd0);
        end
        chk("drain.pop_valid", 32'(pop_valid), 32'd0);
        pop_ready = 1'b0;
        tick();
        chk("drain.credit_end", 32'(credit_return), 32'd0);

        // Streaming 0..9: pop_ready at empty has no effect, then steady occupancy 1.
        push_valid = 1'b1; push_data = 8'd0; pop_ready = 1'b1;
        tick();
        chk("stream.first_credit", 32'(credit_return), 32'd0);
        for (int i = 1; i <= 9; i++) begin
            chk("stream.data", 32'(pop_data), 32'(i - 1));
            push_data = 8'(i);
            tick();
            chk("stream.occ",    32'(occupancy), 32'd1);
            chk("stream.credit", 32'(credit_return), 32'd1);
        end
        push_valid = 1'b0;
        chk("stream.last", 32'(pop_data), 32'd9);
        tick();
        chk("stream.occ_end", 32'(occupancy), 32'd0);
        chk("stream.credit_end", 32'(credit_return), 32'd1);
        pop_ready = 1'b0;
        tick();

        // Push while full with a concurrent pop: beat dropped, occupancy to Depth-1.
        for (int i = 1; i <= 3; i++) begin
            push_valid = 1'b1; push_data = 8'(i * 8'h11);
            tick();
        end
        chk("ovf.full_before", 32'(full), 32'd1);
        push_data = 8'h44; pop_ready = 1'b1;
        tick();
        push_valid = 1'b0;
        chk("ovf.occ",    32'(occupancy), 32'd2);
        chk("ovf.full",   32'(full), 32'd0);
        chk("ovf.credit", 32'(credit_return), 32'd1);
        chk("ovf.data1",  32'(pop_data), 32'h22);
        tick();
        chk("ovf.data2",  32'(pop_data), 32'h33);
        tick();
        chk("ovf.dropped", 32'(pop_valid), 32'd0);
        pop_ready = 1'b0;
        tick();

        // Asynchronous reset with occupancy 2 and a credit pending.
        for (int i = 0; i < 3; i++) begin
            push_valid = 1'b1; push_data = 8'(8'h55 + i);
            tick();
        end
        push_valid = 1'b0; pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
        chk("prerst.occ",    32'(occupancy), 32'd2);
        chk("prerst.credit", 32'(credit_return), 32'd1);
        #1 rst = 1'b1;
        #1;
        idle_state("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        push_valid = 1'b1; push_data = 8'h77;
        tick();
        push_valid = 1'b0;
        chk("postrst.pop_valid", 32'(pop_valid), 32'd1);
        chk("postrst.data",      32'(pop_data), 32'h77);
        chk("postrst.occ",       32'(occupancy), 32'd1);
        pop_ready = 1'b1;
        tick();
        chk("postrst.credit", 32'(credit_return), 32'd1);
        chk("postrst.occ0",   32'(occupancy), 32'd0);
        pop_ready = 1'b0;
        tick();

        // Random traffic from an issuer holding Depth credits.
        credits = D;
        n_pop   = 0;
        n_cred  = 0;
        for (int cyc = 0; cyc < 10020; cyc++) begin
            if (credit_return) begin
                credits++;
                n_cred++;
            end
            chk("rand.occ",       32'(occupancy), 32'(q.size()));
            chk("rand.pop_valid", 32'(pop_valid), 32'(q.size() != 0));
            pop_ready = (cyc >= 10000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (pop_valid && pop_ready) begin
                chk("rand.data", 32'(pop_data), 32'(q[0]));
                void'(q.pop_front());
                n_pop++;
            end
            push_valid = (cyc < 10000) && (credits > 0) && ($urandom_range(0, 2) != 0);
            push_data  = 8'($urandom);
            if (push_valid) begin
                q.push_back(push_data);
                credits--;
            end
            tick();
        end
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        chk("rand.credits_eq_pops", 32'(n_cred), 32'(n_pop));
        chk("rand.issuer_credits",  32'(credits), 32'(D));
        idle_state("end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
